mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the i-cache refill path (read-only) and the d-cache refill/writeback path (read or write).
- Sits between both cache miss engines and the memory interface, below the MEM and IF stages.
- Grants one whole-line burst at a time, tracks beats, and routes read data back to the owner.
- Exactly one transaction is outstanding at any time.

Parameters:
- ADDR_WIDTH, 26, word-address width of requests and the memory port.
- DATA_WIDTH, 32, beat width.
- LINE_WORDS, 4, beats per burst; power of two, minimum 2.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  i-cache line-read request
i_req_addr  in  ADDR_WIDTH  line-aligned word address
i_req_ready  out  1  i-cache request accepted this cycle
i_resp_valid  out  1  read beat for i-cache
i_resp_last  out  1  final beat of i-cache burst
d_req_valid  in  1  d-cache request
d_req_write  in  1  1 = writeback line, 0 = refill read
d_req_addr  in  ADDR_WIDTH  line-aligned word address
d_req_ready  out  1  d-cache request accepted this cycle
d_wdata  in  DATA_WIDTH  writeback beat
d_wdata_valid  in  1  writeback beat present
d_wdata_ready  out  1  writeback beat consumed
d_resp_valid  out  1  read beat for d-cache
d_resp_last  out  1  final beat of d-cache burst
d_wr_done  out  1  one-cycle pulse, writeback complete
resp_data  out  DATA_WIDTH  read beat data, shared by both owners
mem_req_valid  out  1  burst request to memory
mem_req_write  out  1  burst direction
mem_req_addr  out  ADDR_WIDTH  burst base address
mem_req_ready  in  1  memory accepts request
mem_wdata  out  DATA_WIDTH  write beat
mem_wdata_valid  out  1  write beat valid
mem_wdata_ready  in  1  memory accepts write beat
mem_rdata  in  DATA_WIDTH  read beat
mem_rdata_valid  in  1  read beat valid
mem_write_done  in  1  memory write acknowledge

Behaviour:
- Reset: every output is 0. State goes to IDLE, beat_cnt to 0, owner register to D, rr_last register to I. Reset mid-burst abandons the burst; no response or done pulse follows.
- States and transitions:
  - IDLE -> ADDR: on a request handshake.
  - ADDR -> RD_DATA: on mem_req_ready for a read burst.
  - ADDR -> WR_DATA: on mem_req_ready for a write burst.
  - RD_DATA -> IDLE: on the last read beat.
  - WR_DATA -> WR_ACK: on the last write beat.
  - WR_ACK -> IDLE: on mem_write_done.
- IDLE, request acceptance:
  - The winner's *_req_ready is asserted combinationally, only in IDLE. The loser's ready stays 0.
  - On the handshake edge the block latches the address, direction and owner (i-cache requests are always reads) and goes to ADDR.
  - A request arriving in IDLE therefore takes 1 cycle to reach mem_req_valid.
- ADDR: mem_req_valid, mem_req_write and mem_req_addr come from registers and are held stable until mem_req_ready.
- RD_DATA:
  - resp_data = mem_rdata, combinational passthrough.
  - The owner's resp_valid = mem_rdata_valid. The other owner's resp_valid stays 0.
  - beat_cnt increments per beat. resp_last is asserted when beat_cnt == LINE_WORDS-1.
  - On the last beat: return to IDLE and clear beat_cnt. The next grant can occur in the cycle after the last beat.
- WR_DATA:
  - mem_wdata = d_wdata; mem_wdata_valid = d_wdata_valid; d_wdata_ready = mem_wdata_ready.
  - A beat completes when both valid and ready are high. After LINE_WORDS beats, go to WR_ACK.
- WR_ACK: on mem_write_done, pulse d_wr_done for one cycle and return to IDLE.
- Ignored inputs: mem_rdata_valid outside RD_DATA and mem_write_done outside WR_ACK are ignored; simulation assertions flag them.
- Requesters may drop valid after their handshake; latched state is unaffected.
- beat_cnt is $clog2(LINE_WORDS) bits wide and wraps to 0 on the last beat.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration. On simultaneous requests the requester not equal to rr_last wins; rr_last updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority, D over I. rr_last is not implemented.
- A single request always wins immediately in both modes.

Decomposition:
- mips_core_pkg holds: the mem_arb_state_t enum (IDLE, ADDR, RD_DATA, WR_DATA, WR_ACK), the mem_arb_owner_t enum (OWNER_I, OWNER_D), and the LINE_WORDS default constant.
- One combinational sub-module, mem_arb_picker: inputs i_req_valid, d_req_valid, rr_last; outputs grant_i, grant_d. It contains the only MEM_ARB_RR_EN conditional.

Test Plan:
- I read alone:
  - Stimulus: i_req addr 0x100; mem_req_ready 1 cycle later; beats 0xA0..0xA3 with gaps.
  - Expected: mem_req_addr=0x100 with write=0; i_resp_valid on exactly 4 beats; i_resp_last on 0xA3; d_resp_valid never asserted.
- D writeback:
  - Stimulus: d_req_write=1, addr 0x200; 4 beats with mem_wdata_ready toggling; mem_write_done 3 cycles after the last beat.
  - Expected: mem_wdata sequence matches the input; exactly one d_wr_done pulse; return to IDLE.
- Simultaneous requests, feature undefined:
  - Stimulus: I and D both request in the same cycle.
  - Expected: D granted first; I granted the cycle after D's last beat.
- Simultaneous requests, MEM_ARB_RR_EN defined:
  - Stimulus: back-to-back simultaneous I and D requests, repeated.
  - Expected: grants alternate D, I, D, I.
- Reset mid-burst:
  - Stimulus: assert rst_n low after read beat 2.
  - Expected: all outputs 0 immediately; remaining beats ignored; a fresh I request completes normally.
- Spurious memory signals:
  - Stimulus: mem_rdata_valid and mem_write_done pulsed while in IDLE.
  - Expected: no resp_valid, no d_wr_done, state unchanged.

Source files
------------

// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared state/owner types and line size for the memory port arbiter.
package mips_core_pkg;
    typedef enum logic [2:0] {IDLE, ADDR, RD_DATA, WR_DATA, WR_ACK} mem_arb_state_t;
    typedef enum logic {OWNER_I, OWNER_D} mem_arb_owner_t;
    localparam int MEM_ARB_LINE_WORDS = 4;
endpackage

// File: rtl/mem_arb_picker.sv
// mem_arb_picker: picks the i-cache or d-cache requester.
// MEM_ARB_RR_EN selects round-robin; otherwise fixed priority with D over I.
module mem_arb_picker
    import mips_core_pkg::*;
(
    input  logic i_req_valid,
    input  logic d_req_valid,
    input  logic rr_last,
    output logic grant_i,
    output logic grant_d
);
`ifdef MEM_ARB_RR_EN
    // On a tie the requester that did not win last time goes first
    assign grant_d = d_req_valid & (~i_req_valid | (rr_last == OWNER_I));
    assign grant_i = i_req_valid & (~d_req_valid | (rr_last == OWNER_D));
`else
    logic w_unused;
    assign w_unused = rr_last;
    assign grant_d  = d_req_valid;
    assign grant_i  = i_req_valid & ~d_req_valid;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one burst memory port between i-cache refills and d-cache refill/writeback.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority (D over I).
module mem_port_arbiter
    import mips_core_pkg::*;
#(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = MEM_ARB_LINE_WORDS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_req_ready,
    output logic                  i_resp_valid,
    output logic                  i_resp_last,
    input  logic                  d_req_valid,
    input  logic                  d_req_write,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    output logic                  d_req_ready,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  d_wdata_valid,
    output logic                  d_wdata_ready,
    output logic                  d_resp_valid,
    output logic                  d_resp_last,
    output logic                  d_wr_done,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  mem_req_valid,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ready,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wdata_valid,
    input  logic                  mem_wdata_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rdata_valid,
    input  logic                  mem_write_done
);
    localparam int CW = $clog2(LINE_WORDS);

    mem_arb_state_t  r_state;
    mem_arb_owner_t  r_owner;
    mem_arb_owner_t  r_rr_last;
    logic [CW-1:0]   r_beat_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic            r_write;
    logic            r_wr_done;

    logic w_grant_i, w_grant_d, w_idle, w_rd, w_wr, w_rbeat, w_wbeat, w_last;

    mem_arb_picker u_picker (
        .i_req_valid(i_req_valid),
        .d_req_valid(d_req_valid),
        .rr_last    (r_rr_last),
        .grant_i    (w_grant_i),
        .grant_d    (w_grant_d)
    );

    assign w_idle  = r_state == IDLE;
    assign w_rd    = r_state == RD_DATA;
    assign w_wr    = r_state == WR_DATA;
    assign w_rbeat = w_rd & mem_rdata_valid;
    assign w_wbeat = w_wr & d_wdata_valid & mem_wdata_ready;
    assign w_last  = r_beat_cnt == CW'(LINE_WORDS - 1);

    assign i_req_ready     = w_idle & w_grant_i;
    assign d_req_ready     = w_idle & w_grant_d;
    assign i_resp_valid    = w_rbeat & (r_owner == OWNER_I);
    assign d_resp_valid    = w_rbeat & (r_owner == OWNER_D);
    assign i_resp_last     = i_resp_valid & w_last;
    assign d_resp_last     = d_resp_valid & w_last;
    assign resp_data       = w_rd ? mem_rdata : '0;
    assign mem_req_valid   = r_state == ADDR;
    assign mem_req_write   = mem_req_valid & r_write;
    assign mem_req_addr    = mem_req_valid ? r_addr : '0;
    assign mem_wdata       = w_wr ? d_wdata : '0;
    assign mem_wdata_valid = w_wr & d_wdata_valid;
    assign d_wdata_ready   = w_wr & mem_wdata_ready;
    assign d_wr_done       = r_wr_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_owner    <= OWNER_D;
            r_rr_last  <= OWNER_I;
            r_beat_cnt <= '0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wr_done  <= 1'b0;
        end else begin
            r_wr_done <= (r_state == WR_ACK) & mem_write_done;
            case (r_state)
                IDLE: if (w_grant_i | w_grant_d) begin
                    r_addr     <= w_grant_d ? d_req_addr : i_req_addr;
                    r_write    <= w_grant_d & d_req_write;
                    r_owner    <= w_grant_d ? OWNER_D : OWNER_I;
                    r_rr_last  <= w_grant_d ? OWNER_D : OWNER_I;
                    r_beat_cnt <= '0;
                    r_state    <= ADDR;
                end
                ADDR: if (mem_req_ready) r_state <= r_write ? WR_DATA : RD_DATA;
                RD_DATA: if (w_rbeat) begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                    if (w_last) r_state <= IDLE;
                end
                WR_DATA: if (w_wbeat) begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                    if (w_last) r_state <= WR_ACK;
                end
                WR_ACK: if (mem_write_done) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Stray memory handshakes are dropped by the FSM; flag them in simulation
    a_rdata_in_burst: assert property (@(posedge clk) disable iff (!rst_n)
        mem_rdata_valid |-> w_rd)
        else $warning("mem_rdata_valid ignored outside a read burst");
    a_done_in_ack: assert property (@(posedge clk) disable iff (!rst_n)
        mem_write_done |-> (r_state == WR_ACK))
        else $warning("mem_write_done ignored outside write acknowledge");
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a transaction-level model checked every cycle.
module tb_mem_port_arbiter;
    localparam int AW = 26, DW = 32, LW = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic i_req_valid = 0, d_req_valid = 0, d_req_write = 0, d_wdata_valid = 0;
    logic mem_req_ready = 0, mem_wdata_ready = 0, mem_rdata_valid = 0, mem_write_done = 0;
    logic [AW-1:0] i_req_addr = '0, d_req_addr = '0;
    logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
    logic i_req_ready, i_resp_valid, i_resp_last, d_req_ready, d_wdata_ready;
    logic d_resp_valid, d_resp_last, d_wr_done, mem_req_valid, mem_req_write, mem_wdata_valid;
    logic [DW-1:0] resp_data, mem_wdata;
    logic [AW-1:0] mem_req_addr;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_resp_valid(i_resp_valid), .i_resp_last(i_resp_last),
        .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
        .d_req_ready(d_req_ready), .d_wdata(d_wdata), .d_wdata_valid(d_wdata_valid),
        .d_wdata_ready(d_wdata_ready), .d_resp_valid(d_resp_valid), .d_resp_last(d_resp_last),
        .d_wr_done(d_wr_done), .resp_data(resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready), .mem_wdata(mem_wdata), .mem_wdata_valid(mem_wdata_valid),
        .mem_wdata_ready(mem_wdata_ready), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
        .mem_write_done(mem_write_done)
    );

    logic [100:0] w_outs;
    assign w_outs = {i_req_ready, i_resp_valid, i_resp_last, d_req_ready, d_wdata_ready,
                     d_resp_valid, d_resp_last, d_wr_done, resp_data, mem_req_valid,
                     mem_req_write, mem_req_addr, mem_wdata, mem_wdata_valid};

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction model: stage 0 idle, 1 waiting for memory to take the request,
    // 2 moving beats, 3 waiting for write acknowledge
    int m_stage = 0, m_beats = 0;
    bit m_own_d = 0, m_wr = 0, m_done = 0, m_last_d = 0;
    logic [AW-1:0] m_addr = '0;

    int i_beats = 0, d_beats = 0, dones = 0;
    logic [DW-1:0] last_i_data = '0;
    logic [AW-1:0] cap_addr = '0;
    logic cap_wr = 0;
    bit grants[$];
    logic [DW-1:0] wlog[$];

    always @(negedge clk) begin
        bit gi, gd, rd, wr, bt;
        logic [100:0] e;
        gi = 0; gd = 0;
        if (!rst_n) begin
            m_stage = 0; m_beats = 0; m_own_d = 0; m_wr = 0; m_done = 0; m_last_d = 0;
            chk("outs_in_reset", {27'd0, w_outs}, 128'd0);
        end else begin
            if (m_stage == 0) begin
                if (i_req_valid && d_req_valid) begin
                    gd = RR ? !m_last_d : 1'b1;
                    gi = !gd;
                end else begin
                    gd = d_req_valid;
                    gi = i_req_valid;
                end
            end
            rd = m_stage == 2 && !m_wr;
            wr = m_stage == 2 && m_wr;
            e = {gi, rd && !m_own_d && mem_rdata_valid, rd && !m_own_d && mem_rdata_valid && m_beats == LW-1,
                 gd, wr && mem_wdata_ready, rd && m_own_d && mem_rdata_valid,
                 rd && m_own_d && mem_rdata_valid && m_beats == LW-1, m_done,
                 rd ? mem_rdata : 32'd0, m_stage == 1, m_stage == 1 && m_wr,
                 m_stage == 1 ? m_addr : 26'd0, wr ? d_wdata : 32'd0, wr && d_wdata_valid};
            chk("outs", {27'd0, w_outs}, {27'd0, e});
            m_done = m_stage == 3 && mem_write_done;
            if (m_stage == 0 && (gi || gd)) begin
                m_own_d = gd; m_last_d = gd; m_wr = gd && d_req_write;
                m_addr = gd ? d_req_addr : i_req_addr; m_beats = 0; m_stage = 1;
            end else if (m_stage == 1 && mem_req_ready) m_stage = 2;
            else if (m_stage == 2) begin
                bt = m_wr ? (d_wdata_valid && mem_wdata_ready) : mem_rdata_valid;
                if (bt) m_beats++;
                if (m_beats == LW) m_stage = m_wr ? 3 : 0;
            end else if (m_stage == 3 && mem_write_done) m_stage = 0;
            if (i_resp_valid) i_beats++;
            if (i_resp_last) last_i_data = resp_data;
            if (d_resp_valid) d_beats++;
            if (d_wr_done) dones++;
            if (i_req_ready && i_req_valid) grants.push_back(1'b0);
            if (d_req_ready && d_req_valid) grants.push_back(1'b1);
            if (mem_wdata_valid && mem_wdata_ready) wlog.push_back(mem_wdata);
            if (mem_req_valid && mem_req_ready) begin cap_addr = mem_req_addr; cap_wr = mem_req_write; end
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask

    task automatic clear_logs();
        i_beats = 0; d_beats = 0; dones = 0; grants.delete(); wlog.delete();
    endtask

    task automatic mem_accept();
        int c;
        for (c = 0; c < 20 && !mem_req_valid; c++) tick();
        if (!mem_req_valid) chk("memreq_timeout", 0, 1);
        mem_req_ready = 1; tick(); mem_req_ready = 0;
    endtask

    task automatic serve_read(input logic [DW-1:0] base, input bit gaps);
        mem_accept();
        for (int b = 0; b < LW; b++) begin
            if (gaps) tick();
            mem_rdata = base + DW'(b); mem_rdata_valid = 1; tick(); mem_rdata_valid = 0;
        end
    endtask

    initial begin
        int k;
        bit first_d;
        repeat (2) tick();
        chk("reset_outs", {27'd0, w_outs}, 128'd0);
        rst_n = 1; tick();

        // I-cache read alone, beats with gaps
        clear_logs();
        i_req_valid = 1; i_req_addr = 26'h100; tick(); i_req_valid = 0;
        serve_read(32'hA0, 1);
        chk("i_addr", cap_addr, 26'h100);
        chk("i_write", cap_wr, 0);
        chk("i_beats", i_beats, 4);
        chk("i_last_data", last_i_data, 32'hA3);
        chk("i_no_d_resp", d_beats, 0);

        // D-cache writeback with a toggling write-ready
        clear_logs();
        d_req_valid = 1; d_req_write = 1; d_req_addr = 26'h200; tick(); d_req_valid = 0; d_req_write = 0;
        mem_accept();
        k = 0;
        for (int c = 0; c < 20 && k < LW; c++) begin
            mem_wdata_ready = c[0]; d_wdata = 32'hD0 + DW'(k); d_wdata_valid = 1;
            tick();
            if (mem_wdata_ready) k++;
        end
        d_wdata_valid = 0; mem_wdata_ready = 0;
        tick(); tick(); mem_write_done = 1; tick(); mem_write_done = 0; tick(); tick();
        chk("wb_addr", cap_addr, 26'h200);
        chk("wb_write", cap_wr, 1);
        chk("wb_count", wlog.size(), 4);
        for (int i = 0; i < wlog.size(); i++) chk("wb_data", wlog[i], 32'hD0 + i);
        chk("wb_done_pulses", dones, 1);

        // Simultaneous requests; last grant was D so round-robin favours I here
        clear_logs();
        first_d = !RR;
        i_req_valid = 1; i_req_addr = 26'h300; d_req_valid = 1; d_req_addr = 26'h400; tick();
        if (first_d) d_req_valid = 0; else i_req_valid = 0;
        serve_read(32'hB0, 0);
        chk("second_ready_after_last", first_d ? i_req_ready : d_req_ready, 1);
        tick(); i_req_valid = 0; d_req_valid = 0;
        serve_read(32'hC0, 0);
        chk("tie_grants", grants.size(), 2);
        if (grants.size() == 2) begin
            chk("tie_first", grants[0], first_d);
            chk("tie_second", grants[1], !first_d);
        end
        chk("tie_i_beats", i_beats, 4);
        chk("tie_d_beats", d_beats, 4);

        // Fresh reset, then both requesters held high across four bursts
        rst_n = 0; tick(); rst_n = 1; tick();
        clear_logs();
        i_req_valid = 1; i_req_addr = 26'h500; d_req_valid = 1; d_req_addr = 26'h600;
        for (int n = 0; n < 4; n++) begin
            serve_read(32'h40 * DW'(n), 0);
            if (n == 3) begin i_req_valid = 0; d_req_valid = 0; end
        end
        tick();
        chk("hold_grants", grants.size(), 4);
        for (int i = 0; i < grants.size() && i < 4; i++)
            chk("hold_order", grants[i], RR ? (i % 2 == 0) : 1'b1);

        // Reset in the middle of a read burst
        clear_logs();
        i_req_valid = 1; i_req_addr = 26'h700; tick(); i_req_valid = 0;
        mem_accept();
        for (int b = 0; b < 2; b++) begin
            mem_rdata = 32'hF0 + DW'(b); mem_rdata_valid = 1; tick();
        end
        mem_rdata = 32'hF2; rst_n = 0; #1;
        chk("rst_mid_outs", {27'd0, w_outs}, 128'd0);
        clear_logs();
        tick(); mem_rdata = 32'hF3; tick(); rst_n = 1; tick(); mem_rdata_valid = 0; tick();
        chk("rst_ignored_beats", i_beats + d_beats, 0);
        i_req_valid = 1; i_req_addr = 26'h800; tick(); i_req_valid = 0;
        serve_read(32'h10, 0);
        chk("rst_fresh_beats", i_beats, 4);
        chk("rst_fresh_last", last_i_data, 32'h13);

        // Stray memory handshakes while idle
        clear_logs();
        mem_rdata_valid = 1; mem_write_done = 1; tick(); mem_rdata_valid = 0; mem_write_done = 0; tick();
        chk("spur_resp", i_beats + d_beats, 0);
        chk("spur_done", dones, 0);
        d_req_valid = 1; d_req_addr = 26'h900; #1;
        chk("spur_still_idle", d_req_ready, 1);
        tick(); d_req_valid = 0;
        serve_read(32'h20, 0);
        chk("spur_d_beats", d_beats, 4);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end
endmodule
